rvc_asap_5pl_vga_ctrl: RTL and testbench



---
 rtl/rvc_asap_pkg.sv | 36 +++
 rtl/rvc_asap_5pl_vga_ctrl_sync_gen.sv | 61 ++++++
 rtl/rvc_asap_5pl_vga_ctrl.sv | 125 ++++++++++++
 tb/tb_rvc_asap_5pl_vga_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared constants and types for the rvc_asap core slice.
// VGA part: 640x480@60Hz timing constants, sync window bounds, framebuffer
// row width in 32-bit words, default colours and the RGB pin struct.
package rvc_asap_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;             // 800
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;             // 525

  localparam int unsigned VGA_HS_START = VGA_H_VISIBLE + VGA_H_FP;          // 656
  localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;     // 751
  localparam int unsigned VGA_VS_START = VGA_V_VISIBLE + VGA_V_FP;          // 490
  localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;     // 491

  localparam int unsigned VGA_WORDS_PER_LINE = 10;

  localparam logic [11:0] VGA_FG_COLOR = 12'hFFF;
  localparam logic [11:0] VGA_BG_COLOR = 12'h000;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } t_vga_rgb;

endpackage

// File: rtl/rvc_asap_5pl_vga_ctrl_sync_gen.sv
// rvc_asap_5pl_vga_sync_gen: horizontal/vertical raster counters and the
// stage-0 terms derived from them.
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   visible      : current (hcnt, vcnt) lies in the visible area
//   h_sync_pre   : horizontal sync level (active low), not yet delayed
//   v_sync_pre   : vertical sync level (active low), not yet delayed
//   line         : framebuffer row, vcnt>>1
//   word         : word within row, hcnt>>6
//   hcnt         : raw horizontal counter, used for pixel selection
module rvc_asap_5pl_vga_sync_gen
  import rvc_asap_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       visible,
  output logic       h_sync_pre,
  output logic       v_sync_pre,
  output logic [8:0] line,
  output logic [3:0] word,
  output logic [9:0] hcnt
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] vcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  always_comb begin
    visible    = (hcnt < 10'(H_VISIBLE)) && (vcnt < 10'(V_VISIBLE));
    h_sync_pre = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
    v_sync_pre = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
    line       = vcnt[9:1];
    word       = hcnt[9:6];
  end

endmodule

// File: rtl/rvc_asap_5pl_vga_ctrl.sv
// rvc_asap_5pl_vga_ctrl: VGA display controller, read side of the VGA memory.
// 640x480@60Hz from a 320x240 1bpp framebuffer, pixel-doubled.
//   CLK_25    : 25 MHz pixel clock
//   Rst_N     : asynchronous active-low reset
//   rdaddress : registered word address to the VGA memory
//   q         : memory read data, valid one clock after rdaddress
//   RED/GREEN/BLUE : 4-bit DAC outputs
//   h_sync/v_sync  : active-low syncs, aligned with RGB
// Pipeline: counters -> rdaddress -> q -> output registers (3 clocks).
// Build option VGA_TEST_PATTERN_EN: output 8 colour bars, ignoring q.
module rvc_asap_5pl_vga_ctrl
  import rvc_asap_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter logic [11:0] FG_COLOR  = VGA_FG_COLOR,
  parameter logic [11:0] BG_COLOR  = VGA_BG_COLOR
) (
  input  logic        CLK_25,
  input  logic        Rst_N,
  output logic [12:0] rdaddress,
  input  logic [31:0] q,
  output logic [3:0]  RED,
  output logic [3:0]  GREEN,
  output logic [3:0]  BLUE,
  output logic        h_sync,
  output logic        v_sync
);

  logic       visible_s0, h_sync_pre_s0, v_sync_pre_s0;
  logic [8:0] line_s0;
  logic [3:0] word_s0;
  logic [9:0] hcnt_s0;

  rvc_asap_5pl_vga_sync_gen #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_sync_gen (
    .clk        (CLK_25),
    .rst_n      (Rst_N),
    .visible    (visible_s0),
    .h_sync_pre (h_sync_pre_s0),
    .v_sync_pre (v_sync_pre_s0),
    .line       (line_s0),
    .word       (word_s0),
    .hcnt       (hcnt_s0)
  );

  // line*10 as (line<<3)+(line<<1); max 239*10+9 = 2399 fits 13 bits
  logic [12:0] addr_s0;
  assign addr_s0 = 13'({line_s0, 3'b000}) + 13'({line_s0, 1'b0}) + 13'(word_s0);

  logic       vis_d1, vis_d2;
  logic       hs_d1, hs_d2;
  logic       vs_d1, vs_d2;
  logic [9:0] hcnt_d1, hcnt_d2;
  t_vga_rgb   pix_rgb;
  t_vga_rgb   rgb_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  logic       unused_q;
  assign bar      = 3'(hcnt_d2 / 10'd80);
  assign unused_q = ^q;
  always_comb begin
    pix_rgb.red   = {4{bar[2]}};
    pix_rgb.green = {4{bar[1]}};
    pix_rgb.blue  = {4{bar[0]}};
  end
`else
  logic unused_hcnt_bits;
  assign unused_hcnt_bits = ^{hcnt_d2[9:6], hcnt_d2[0]};
  // bit 0 of a word is its leftmost pixel; each bit spans two screen pixels
  always_comb begin
    pix_rgb = q[hcnt_d2[5:1]] ? t_vga_rgb'(FG_COLOR) : t_vga_rgb'(BG_COLOR);
  end
`endif

  always_ff @(posedge CLK_25 or negedge Rst_N) begin
    if (!Rst_N) begin
      rdaddress <= '0;
      vis_d1    <= 1'b0;
      vis_d2    <= 1'b0;
      hs_d1     <= 1'b1;
      hs_d2     <= 1'b1;
      vs_d1     <= 1'b1;
      vs_d2     <= 1'b1;
      hcnt_d1   <= '0;
      hcnt_d2   <= '0;
      rgb_q     <= '0;
      h_sync    <= 1'b1;
      v_sync    <= 1'b1;
    end else begin
      rdaddress <= visible_s0 ? addr_s0 : '0;
      vis_d1    <= visible_s0;
      vis_d2    <= vis_d1;
      hs_d1     <= h_sync_pre_s0;
      hs_d2     <= hs_d1;
      vs_d1     <= v_sync_pre_s0;
      vs_d2     <= vs_d1;
      hcnt_d1   <= hcnt_s0;
      hcnt_d2   <= hcnt_d1;
      rgb_q     <= vis_d2 ? pix_rgb : '0;
      h_sync    <= hs_d2;
      v_sync    <= vs_d2;
    end
  end

  assign RED   = rgb_q.red;
  assign GREEN = rgb_q.green;
  assign BLUE  = rgb_q.blue;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_ctrl.sv
// Testbench for rvc_asap_5pl_vga_ctrl. Vertical timing is shortened so whole
// frames, v_sync and frame wrap fit in a short run; horizontal timing is the
// real 800-clock line. Expected pin values come from raster position and the
// framebuffer contents.
module tb_rvc_asap_5pl_vga_ctrl;
  import rvc_asap_pkg::*;

  localparam int TB_V_VISIBLE = 20;
  localparam int TB_V_FP      = 3;
  localparam int TB_V_SYNC    = 2;
  localparam int TB_V_BP      = 3;
  localparam int HT       = VGA_H_TOTAL;
  localparam int VT       = TB_V_VISIBLE + TB_V_FP + TB_V_SYNC + TB_V_BP;
  localparam int VS_START = TB_V_VISIBLE + TB_V_FP;
  localparam int VS_END   = VS_START + TB_V_SYNC - 1;

  logic        CLK_25 = 1'b0;
  logic        Rst_N  = 1'b0;
  logic [12:0] rdaddress;
  logic [31:0] q = '0;
  logic [3:0]  RED, GREEN, BLUE;
  logic        h_sync, v_sync;

  logic [31:0] mem [0:8191];
  int checks   = 0;
  int failures = 0;
  int n        = 0;   // rising edges since reset release

  rvc_asap_5pl_vga_ctrl #(
    .V_VISIBLE (TB_V_VISIBLE),
    .V_FP      (TB_V_FP),
    .V_SYNC    (TB_V_SYNC),
    .V_BP      (TB_V_BP)
  ) dut (
    .CLK_25    (CLK_25),
    .Rst_N     (Rst_N),
    .rdaddress (rdaddress),
    .q         (q),
    .RED       (RED),
    .GREEN     (GREEN),
    .BLUE      (BLUE),
    .h_sync    (h_sync),
    .v_sync    (v_sync)
  );

  always #20 CLK_25 = ~CLK_25;

  // memory with registered read port
  always @(posedge CLK_25) q <= mem[rdaddress];

  // raster position shown at the pins after edge k, counter state k-lat
  function automatic logic [12:0] exp_addr(input int k);
    int s, h, v;
    if (k < 1) return 13'd0;
    s = k - 1;
    h = s % HT;
    v = (s / HT) % VT;
    if (h >= VGA_H_VISIBLE || v >= TB_V_VISIBLE) return 13'd0;
    return 13'((v / 2) * VGA_WORDS_PER_LINE + (h / 2) / 32);
  endfunction

  function automatic logic [11:0] exp_rgb(input int k);
    int s, h, v, row, col;
    logic [31:0] w;
    logic [2:0]  kb;
    if (k < 3) return 12'h000;
    s = k - 3;
    h = s % HT;
    v = (s / HT) % VT;
    if (h >= VGA_H_VISIBLE || v >= TB_V_VISIBLE) return 12'h000;
    row = v / 2;
    col = h / 2;
    w   = mem[row * VGA_WORDS_PER_LINE + col / 32];
    kb  = 3'(h / 80);
`ifdef VGA_TEST_PATTERN_EN
    return {{4{kb[2]}}, {4{kb[1]}}, {4{kb[0]}}};
`else
    if (kb == 3'd7 && w == 32'h0) return VGA_BG_COLOR;
    return w[col % 32] ? VGA_FG_COLOR : VGA_BG_COLOR;
`endif
  endfunction

  function automatic logic exp_hs(input int k);
    int h;
    if (k < 3) return 1'b1;
    h = (k - 3) % HT;
    return !(h >= VGA_HS_START && h <= VGA_HS_END);
  endfunction

  function automatic logic exp_vs(input int k);
    int v;
    if (k < 3) return 1'b1;
    v = ((k - 3) / HT) % VT;
    return !(v >= VS_START && v <= VS_END);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic check_all();
    check("rdaddress", 32'(rdaddress), 32'(exp_addr(n)));
    check("rgb", 32'({RED, GREEN, BLUE}), 32'(exp_rgb(n)));
    check("h_sync", 32'(h_sync), 32'(exp_hs(n)));
    check("v_sync", 32'(v_sync), 32'(exp_vs(n)));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rdaddress"}, 32'(rdaddress), 32'h0);
    check({tag, "_rgb"}, 32'({RED, GREEN, BLUE}), 32'h0);
    check({tag, "_h_sync"}, 32'(h_sync), 32'h1);
    check({tag, "_v_sync"}, 32'(v_sync), 32'h1);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK_25);
      #1;
      n++;
      check_all();
    end
  endtask

  initial begin
    // directed framebuffer: only the leftmost pixel of row 0 is set
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0001;

    Rst_N = 1'b0;
    repeat (3) @(posedge CLK_25);
    #1;
    check_reset("por");
    @(negedge CLK_25);
    Rst_N = 1'b1;
    n = 0;
    run(VT * HT + 900);   // full frame plus wrap into the next one

    // random framebuffer, loaded while held in reset
    @(negedge CLK_25);
    Rst_N = 1'b0;
    #1;
    check_reset("rst_b");
    for (int i = 0; i < 8192; i++) mem[i] = $urandom;
    @(negedge CLK_25);
    Rst_N = 1'b1;
    n = 0;
    run(10 * HT + 300);   // stop inside the visible area of line 10

    // asynchronous reset between clock edges
    #2;
    Rst_N = 1'b0;
    #1;
    check_reset("async");
    repeat (2) @(posedge CLK_25);
    #1;
    check_reset("held");
    @(negedge CLK_25);
    Rst_N = 1'b1;
    n = 0;
    run(14 * HT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
